fu_exec: RTL

Execution back-end that sits on the issue side of the reservation station. It accepts up to three issued entries per cycle: ALU0, ALU1 and the load/store address unit (AGU). Each entry is executed with a fixed latency, and the block reports per-FU availability back to the reservation station. Completed results are serialised onto a single common data bus (CDB), one per cycle, for wakeup and ROB completion.

---
 rtl/fu_exec.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fu_exec.sv
// rtl/fu_exec.sv - FU0/FU1 ALU and FU2 AGU fixed-latency execute with single-CDB writeback
// Configuration macro: FU_EXEC_CDB_RR_EN (round-robin CDB arbitration; fixed priority FU2>FU0>FU1 when undefined)
module fu_exec #(
    parameter int PREG_WIDTH = 6,
    parameter int ALU_LAT    = 1,
    parameter int AGU_LAT    = 2,
    // Reservation-station entry layout, LSB first
    localparam int F_DATA1 = 0,
    localparam int F_DATA2 = 32,
    localparam int F_IMM   = 64,
    localparam int F_ALUOP = 96,
    localparam int F_CSIGS = 99,
    localparam int CSIGS_W = 4,
    localparam int F_RD    = F_CSIGS + CSIGS_W,
    localparam int F_ROB   = F_RD + PREG_WIDTH,
    localparam int RS_WIDTH = F_ROB + 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [RS_WIDTH-1:0]   instr_in0,
    input  logic [RS_WIDTH-1:0]   instr_in1,
    input  logic [RS_WIDTH-1:0]   instr_in2,
    input  logic [2:0]            instr_valid,
    output logic [2:0]            fu_ready,
    output logic                  cdb_valid,
    output logic [PREG_WIDTH-1:0] cdb_tag,
    output logic [31:0]           cdb_data,
    output logic [5:0]            cdb_rob,
    output logic [1:0]            cdb_fu,
    output logic                  illegal_issue
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                  state_q [3];
    state_t                  state_d [3];
    logic [2:0]              cnt_q   [3];
    logic [31:0]             d1_q    [3];
    logic [31:0]             d2_q    [3];
    logic [31:0]             imm_q   [3];
    logic [2:0]              op_q    [3];
    logic                    src_q   [3];
    logic [PREG_WIDTH-1:0]   rd_q    [3];
    logic [5:0]              rob_q   [3];
    logic [31:0]             res_q   [3];
    logic [31:0]             res_c   [3];
    logic [RS_WIDTH-1:0]     instr   [3];
    logic [2:0]              idle;
    logic [2:0]              done;
    logic [2:0]              issue_ok;
    logic                    gnt_any;
    logic [1:0]              gnt_idx;
    logic                    unused_csigs;

    assign instr[0] = instr_in0;
    assign instr[1] = instr_in1;
    assign instr[2] = instr_in2;

    // Only ALUSrc (c_sigs bit 0) matters to execution
    assign unused_csigs = ^{instr_in0[F_CSIGS+1 +: CSIGS_W-1],
                            instr_in1[F_CSIGS+1 +: CSIGS_W-1],
                            instr_in2[F_CSIGS+1 +: CSIGS_W-1]};

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = a << b[4:0];
            3'b110:  r = a >> b[4:0];
            default: r = $signed(a) >>> b[4:0];
        endcase
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            idle[k]     = (state_q[k] == S_IDLE);
            done[k]     = (state_q[k] == S_DONE);
            issue_ok[k] = instr_valid[k] && idle[k] && !flush;
        end
        res_c[0] = alu(op_q[0], d1_q[0], src_q[0] ? imm_q[0] : d2_q[0]);
        res_c[1] = alu(op_q[1], d1_q[1], src_q[1] ? imm_q[1] : d2_q[1]);
        res_c[2] = d1_q[2] + imm_q[2];
    end

`ifdef FU_EXEC_CDB_RR_EN
    logic [1:0] ptr_q;

    always_comb begin
        logic [2:0] idx;
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        idx     = 3'd0;
        for (int i = 0; i < 3; i++) begin
            idx = {1'b0, ptr_q} + 3'(i);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!gnt_any && done[idx[1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= 2'd0;
        else if (!flush && gnt_any)
            ptr_q <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end
`else
    always_comb begin
        gnt_any = |done;
        gnt_idx = 2'd0;
        if (done[2])      gnt_idx = 2'd2;
        else if (done[0]) gnt_idx = 2'd0;
        else if (done[1]) gnt_idx = 2'd1;
    end
`endif

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            state_d[k] = state_q[k];
            if (flush) begin
                state_d[k] = S_IDLE;
            end else begin
                case (state_q[k])
                    S_IDLE:  if (instr_valid[k]) state_d[k] = S_BUSY;
                    S_BUSY:  if (cnt_q[k] == 3'd0) state_d[k] = S_DONE;
                    S_DONE:  if (gnt_any && gnt_idx == 2'(k)) state_d[k] = S_IDLE;
                    default: state_d[k] = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= S_IDLE;
                cnt_q[k]   <= 3'd0;
                d1_q[k]    <= '0;
                d2_q[k]    <= '0;
                imm_q[k]   <= '0;
                op_q[k]    <= '0;
                src_q[k]   <= 1'b0;
                rd_q[k]    <= '0;
                rob_q[k]   <= '0;
                res_q[k]   <= '0;
            end
            fu_ready      <= 3'b111;
            cdb_valid     <= 1'b0;
            cdb_tag       <= '0;
            cdb_data      <= '0;
            cdb_rob       <= '0;
            cdb_fu        <= '0;
            illegal_issue <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                state_q[k]  <= state_d[k];
                fu_ready[k] <= (state_d[k] == S_IDLE);
                if (flush) begin
                    cnt_q[k] <= 3'd0;
                end else if (issue_ok[k]) begin
                    d1_q[k]  <= instr[k][F_DATA1 +: 32];
                    d2_q[k]  <= instr[k][F_DATA2 +: 32];
                    imm_q[k] <= instr[k][F_IMM +: 32];
                    op_q[k]  <= instr[k][F_ALUOP +: 3];
                    src_q[k] <= instr[k][F_CSIGS];
                    rd_q[k]  <= instr[k][F_RD +: PREG_WIDTH];
                    rob_q[k] <= instr[k][F_ROB +: 6];
                    cnt_q[k] <= (k == 2) ? 3'(AGU_LAT - 1) : 3'(ALU_LAT - 1);
                end else if (state_q[k] == S_BUSY) begin
                    if (cnt_q[k] == 3'd0)
                        res_q[k] <= res_c[k];
                    else
                        cnt_q[k] <= cnt_q[k] - 3'd1;
                end
            end
            // Issue collisions are only illegal when the issue would otherwise be accepted
            if (!flush && |(instr_valid & ~idle))
                illegal_issue <= 1'b1;
            if (flush) begin
                cdb_valid <= 1'b0;
            end else if (gnt_any) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= rd_q[gnt_idx];
                cdb_data  <= res_q[gnt_idx];
                cdb_rob   <= rob_q[gnt_idx];
                cdb_fu    <= gnt_idx;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule
